// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg: shared state encoding, program base addresses and halt opcode
package run_sequencer_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} seq_state_t;

    // Instruction ROM start address of each stored program
    localparam logic [9:0] PROG_BASE [4] = '{10'h000, 10'h080, 10'h100, 10'h180};

    localparam logic [8:0] HALT_INST = 9'h1FF;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: 16-bit execution cycle counter with sync clear and enable
//   clk, rst : clock, sync active-high reset
//   clr      : zero the count (wins over en)
//   en       : count this cycle
//   count    : current count
module run_cycle_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk)
        if (rst || clr) count <= '0;
        else if (en)    count <= count + 16'd1;

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: Start/Ack handshake to PC load/run control over a rotating program set
//   Clk, Reset   : clock, sync active-high reset
//   Start        : high arms a program, falling edge starts it
//   HaltInst     : current instruction is the halt opcode
//   PcLoad       : PC loads PcBase
//   PcBase       : start address of the selected program
//   Going        : PC may advance, fetched instruction valid
//   ProgIdx      : program armed/running (LUT-set select)
//   Ack, Timeout : run finished; finished on the cycle limit instead of a halt
//   CycleCount   : RUN cycles of the current or last run
module run_sequencer
    import run_sequencer_pkg::*;
#(
    parameter int          NUM_PROGS  = 3,
    parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        HaltInst,
    output logic        PcLoad,
    output logic [9:0]  PcBase,
    output logic        Going,
    output logic [1:0]  ProgIdx,
    output logic        Ack,
    output logic        Timeout,
    output logic [15:0] CycleCount
);

    seq_state_t state, state_next;
    logic [1:0] next_prog;
    logic       at_limit, arm_entry, finish;

    // Start has top priority in every state, so a RUN abort and a re-arm from DONE share one path
    always_comb begin
        at_limit   = CycleCount == MAX_CYCLES - 16'd1;
        state_next = Start ? S_ARM :
                     state == S_ARM ? S_RUN :
                     (state == S_RUN && (HaltInst || at_limit)) ? S_DONE : state;
        arm_entry  = state_next == S_ARM && state != S_ARM;
        finish     = state == S_RUN && state_next == S_DONE;
    end

    always_ff @(posedge Clk)
        if (Reset) state <= S_IDLE;
        else       state <= state_next;

    always_ff @(posedge Clk)
        if (Reset) begin
            ProgIdx   <= '0;
            next_prog <= '0;
            Ack       <= 1'b0;
            Timeout   <= 1'b0;
        end else if (arm_entry) begin
            ProgIdx   <= next_prog;
            next_prog <= next_prog == 2'(NUM_PROGS - 1) ? 2'd0 : next_prog + 2'd1;
            Ack       <= 1'b0;
            Timeout   <= 1'b0;
        end else if (finish) begin
            Ack       <= 1'b1;
            Timeout   <= !HaltInst; // a halt on the limit cycle counts as a clean finish
        end

    // The halt/limit cycle itself is counted; an abort clears instead of counting
    run_cycle_counter u_counter (
        .clk   (Clk),
        .rst   (Reset),
        .clr   (arm_entry),
        .en    (state == S_RUN),
        .count (CycleCount)
    );

    assign Going  = state == S_RUN;
    assign PcLoad = state == S_ARM;
    assign PcBase = PROG_BASE[ProgIdx];

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed and random checks of two run_sequencer instances against a behavioural model
module tb_run_sequencer;

    logic clk = 1'b0;
    logic rst, start, halt;
    logic       pc_load [2];
    logic       going   [2];
    logic       ack     [2];
    logic       tmo     [2];
    logic [9:0] pc_base [2];
    logic [1:0] prog_idx[2];
    logic [15:0] cyc    [2];

    int errors = 0;
    int checks = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    run_sequencer #(.NUM_PROGS(3), .MAX_CYCLES(16'hFFFF)) dut_a (
        .Clk(clk), .Reset(rst), .Start(start), .HaltInst(halt),
        .PcLoad(pc_load[0]), .PcBase(pc_base[0]), .Going(going[0]), .ProgIdx(prog_idx[0]),
        .Ack(ack[0]), .Timeout(tmo[0]), .CycleCount(cyc[0])
    );

    run_sequencer #(.NUM_PROGS(3), .MAX_CYCLES(16'd8)) dut_b (
        .Clk(clk), .Reset(rst), .Start(start), .HaltInst(halt),
        .PcLoad(pc_load[1]), .PcBase(pc_base[1]), .Going(going[1]), .ProgIdx(prog_idx[1]),
        .Ack(ack[1]), .Timeout(tmo[1]), .CycleCount(cyc[1])
    );

    // Behavioural model: one record per instance, advanced once per rising edge
    localparam int IDLE = 0, ARMED = 1, RUNNING = 2, FINISHED = 3;
    int base_tbl[4] = '{0, 128, 256, 384};
    int limit[2]    = '{65535, 8};
    int m_mode[2], m_prog[2], m_next[2], m_cnt[2];
    bit m_ack[2], m_tmo[2];

    task automatic model_step(input int i);
        if (rst) begin
            m_mode[i] = IDLE; m_prog[i] = 0; m_next[i] = 0;
            m_cnt[i] = 0; m_ack[i] = 0; m_tmo[i] = 0;
        end else if (start && m_mode[i] != ARMED) begin
            m_mode[i] = ARMED; m_prog[i] = m_next[i]; m_next[i] = (m_next[i] + 1) % 3;
            m_cnt[i] = 0; m_ack[i] = 0; m_tmo[i] = 0;
        end else if (m_mode[i] == ARMED && !start) begin
            m_mode[i] = RUNNING;
        end else if (m_mode[i] == RUNNING) begin
            m_cnt[i]++;
            if (halt) begin
                m_mode[i] = FINISHED; m_ack[i] = 1; m_tmo[i] = 0;
            end else if (m_cnt[i] == limit[i]) begin
                m_mode[i] = FINISHED; m_ack[i] = 1; m_tmo[i] = 1;
            end
        end
    endtask

    always @(posedge clk) for (int i = 0; i < 2; i++) model_step(i);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk)
        if (checking)
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("going[%0d]", i),    going[i],    m_mode[i] == RUNNING);
                chk($sformatf("pc_load[%0d]", i),  pc_load[i],  m_mode[i] == ARMED);
                chk($sformatf("prog_idx[%0d]", i), prog_idx[i], m_prog[i]);
                chk($sformatf("pc_base[%0d]", i),  pc_base[i],  base_tbl[m_prog[i]]);
                chk($sformatf("ack[%0d]", i),      ack[i],      m_ack[i]);
                chk($sformatf("timeout[%0d]", i),  tmo[i],      m_tmo[i]);
                chk($sformatf("cycles[%0d]", i),   cyc[i],      m_cnt[i]);
            end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int exp_prog[3] = '{1, 2, 0};
        rst = 1; start = 0; halt = 0;
        @(posedge clk); #1;
        checking = 1;
        tick(1);
        rst = 0;
        tick(5);
        @(negedge clk);
        chk("idle_going", going[0], 0);
        chk("idle_ack", ack[0], 0);
        chk("idle_prog", prog_idx[0], 0);
        chk("idle_cycles", cyc[0], 0);
        chk("idle_base", pc_base[0], 0);

        // Program 0: arm for 3 cycles, halt on RUN cycle 10 (dut_b times out at 8)
        start = 1; tick(3);
        start = 0; tick(10);
        halt = 1;  tick(1);
        halt = 0;
        @(negedge clk);
        chk("halt10_ack", ack[0], 1);
        chk("halt10_going", going[0], 0);
        chk("halt10_cycles", cyc[0], 10);
        chk("halt10_tmo", tmo[0], 0);
        chk("limit8_cycles", cyc[1], 8);
        chk("limit8_tmo", tmo[1], 1);
        chk("limit8_ack", ack[1], 1);

        // Programs 1, 2 then wrap to 0
        for (int r = 0; r < 3; r++) begin
            start = 1; tick(2);
            @(negedge clk);
            chk("seq_prog", prog_idx[0], exp_prog[r]);
            chk("seq_base", pc_base[0], 128 * exp_prog[r]);
            start = 0; tick(3);
            halt = 1;  tick(1);
            halt = 0;  tick(1);
        end
        @(negedge clk);
        chk("seq_cycles", cyc[0], 3);

        // Halt coinciding with the limit on dut_b: halt wins
        start = 1; tick(1);
        start = 0; tick(8);
        halt = 1;  tick(1);
        halt = 0;
        @(negedge clk);
        chk("limit_halt_tmo", tmo[1], 0);
        chk("limit_halt_cycles", cyc[1], 8);
        chk("limit_halt_ack", ack[1], 1);

        // Abort on RUN cycle 4 with a simultaneous halt: Start wins
        start = 1; tick(1);
        start = 0; tick(4);
        start = 1; halt = 1; tick(1);
        halt = 0;
        @(negedge clk);
        chk("abort_ack", ack[0], 0);
        chk("abort_load", pc_load[0], 1);
        chk("abort_cycles", cyc[0], 0);
        chk("abort_prog", prog_idx[0], 0);
        start = 0; tick(2);
        halt = 1;  tick(1);
        halt = 0;  tick(2);

        // Reset during RUN cycle 5
        start = 1; tick(1);
        start = 0; tick(5);
        rst = 1;   tick(1);
        rst = 0;
        @(negedge clk);
        chk("rst_going", going[0], 0);
        chk("rst_cycles", cyc[0], 0);
        chk("rst_prog", prog_idx[0], 0);
        start = 1; tick(1);
        start = 0;
        chk("rst_rearm_prog", prog_idx[0], 0);
        tick(3);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst   = $urandom_range(0, 299) == 0;
            start = start ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 24) == 0);
            halt  = $urandom_range(0, 11) == 0;
            tick(1);
        end
        rst = 0; start = 0; halt = 0;
        tick(2);
        @(negedge clk);
        checking = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Program-run controller for the 9-bit single-cycle core. It converts the bench's Start/Ack handshake into PC load/run control. It steps through the three stored programs in order and selects the matching jump/memory LUT set for each one. It also counts execution cycles and forces termination on a halt instruction or a runaway program. It sits between the bench-facing top-level pins and the program counter, control decoder and LUT muxes.

## Interface
Parameters:
- NUM_PROGS, 3: number of programs in instruction ROM; legal values 1–4.
- MAX_CYCLES, 16'hFFFF: run-length limit in cycles; reaching it forces DONE with Timeout.

Ports:
- Clk  in  1  system clock; all state updates on posedge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  bench start level; high = hold/arm, falling edge = begin execution.
- HaltInst  in  1  decoder flag: current instruction is 9'h1FF (halt).
- PcLoad  out  1  PC loads PcBase this cycle.
- PcBase  out  10  start address of the selected program.
- Going  out  1  PC may advance and the fetched instruction is valid.
- ProgIdx  out  2  program currently armed/running; drives LUT-set select.
- Ack  out  1  program finished; held until the next Start.
- Timeout  out  1  last run ended at MAX_CYCLES rather than on a halt.
- CycleCount  out  16  RUN cycles of the current or last run.

## Operation
- State register uses 4 states: IDLE, ARM, RUN, DONE.
- Reset values:
  - state=IDLE; Going=0; PcLoad=0; Ack=0; Timeout=0; CycleCount=0.
  - ProgIdx=0; internal NextProg=0; PcBase=PROG_BASE[0].
- IDLE: all controls low. Start=1 -> ARM.
- Entry to ARM from any state:
  - ProgIdx<=NextProg.
  - NextProg<=(NextProg==NUM_PROGS-1)?0:NextProg+1.
  - CycleCount<=0; Timeout<=0; Ack<=0.
- ARM: PcLoad=1, Going=0. Stays in ARM while Start=1. Start=0 -> RUN.
- RUN: Going=1, PcLoad=0, CycleCount increments every RUN cycle. Transition priority, highest first:
  - Start=1 -> ARM. The run is aborted, Ack stays 0, and the next program is armed.
  - HaltInst=1 -> DONE with Ack=1, Timeout=0.
  - CycleCount==MAX_CYCLES-1 -> DONE with Ack=1, Timeout=1.
- DONE: Going=0, Ack=1, CycleCount frozen. Start=1 -> ARM.
- PcBase is combinational: PROG_BASE[ProgIdx].
- Going and PcLoad are decoded from the registered state, so they are glitch-free. Ack and Timeout are registered.
- CycleCount cannot pass MAX_CYCLES, because the timeout forces DONE first.
- ProgIdx wraps NUM_PROGS-1 -> 0. A fourth Start with NUM_PROGS=3 runs program 0 again.
- Reset asserted in any state returns all outputs to their reset values the next cycle, including NextProg=0.
- HaltInst is ignored outside RUN.

## Timing
- Start rising at edge k: state=ARM and PcLoad=1 from cycle k+1.
- Start falling (first low at edge m): state=RUN and Going=1 from cycle m+1. The PC advances from PcBase starting on edge m+2.
- Halt sampled at edge h: Going=0 and Ack=1 from cycle h+1. The halt cycle is included in CycleCount.
- Latency from halt to Ack is 1 cycle.
- A halt in the first RUN cycle gives CycleCount=1.
- Start and HaltInst high on the same RUN edge: Start wins -> ARM, Ack=0.
- HaltInst and the MAX_CYCLES limit on the same edge: halt wins, Timeout=0.

## Structure
- Add to package Definitions:
  - typedef enum logic[1:0] seq_state_t {S_IDLE, S_ARM, S_RUN, S_DONE}.
  - Localparam array PROG_BASE[4] of 10-bit ROM start addresses.
  - Localparam HALT_INST=9'h1FF.
- One sub-module, run_cycle_counter: 16-bit counter with sync clear and enable. The sequencer drives clear on ARM entry and enable in RUN.
- The top level replaces its free-running CycleCount with this block's output.
- The top level uses ProgIdx to mux among the per-program jmpLUT/memLUT instances.

## Test plan
- Reset for 2 cycles, then idle for 5: Going=0, Ack=0, ProgIdx=0, CycleCount=0, PcBase=PROG_BASE[0] throughout.
- Start high 3 cycles then low, HaltInst pulsed on the 10th RUN cycle -> PcLoad=1 for 3 cycles, Going=1 for 10 cycles, Ack=1 from the next cycle, CycleCount=10, Timeout=0.
- Three consecutive Start/halt runs, then a fourth Start (NUM_PROGS=3) -> ProgIdx sequence 0,1,2,0, with PcBase tracking PROG_BASE[ProgIdx].
- MAX_CYCLES=8, no halt -> DONE after 8 RUN cycles, CycleCount=8, Ack=1, Timeout=1. Repeat with HaltInst on RUN cycle 8 -> Timeout=0.
- Start reasserted on RUN cycle 4 -> returns to ARM, Ack never rises, ProgIdx advances by 1, CycleCount cleared to 0.
- Reset asserted mid-RUN (cycle 5) -> next cycle shows state IDLE, Going=0, CycleCount=0, ProgIdx=0. The following Start arms program 0.
